// File: rtl/instr_decoder_id.sv
// ID-stage scalar-control decoder: maps the opcode of a flag-stripped instruction
// word to a scalar-register operation and a zero-extended 24-bit immediate, registered at ID/EX.
module instr_decoder_id #(
    parameter int ARQ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [ARQ-3:0] instr,
    output logic [1:0]     sca_reg_op,
    output logic [23:0]    imm
);

    localparam logic [3:0] OPC_INCRI = 4'b0000;
    localparam logic [3:0] OPC_INCRJ = 4'b0001;
    localparam logic [3:0] OPC_SETN  = 4'b0010;
    localparam logic [3:0] OPC_SUMFV = 4'b0011;
    localparam logic [3:0] OPC_MULFV = 4'b0100;
    localparam logic [3:0] OPC_NOP   = 4'b0101;

    localparam logic [1:0] SOP_NONE  = 2'b00;
    localparam logic [1:0] SOP_INCI  = 2'b01;
    localparam logic [1:0] SOP_INCJ  = 2'b10;
    localparam logic [1:0] SOP_SETN  = 2'b11;

    logic [3:0]     w_opcode;
    logic [23:0]    w_imm_field;
    logic [ARQ-7:24] w_unused_rsvd;
    logic [1:0]     w_sca_op;
    logic [23:0]    w_imm;
    logic [1:0]     r_sca_op;
    logic [23:0]    r_imm;

    assign w_opcode      = instr[ARQ-3:ARQ-6];
    assign w_imm_field   = instr[23:0];
    assign w_unused_rsvd = instr[ARQ-7:24];

    // Anything that is not a scalar op (vector ops, NOP, undefined, X) decodes as no-op.
    always_comb begin
        w_sca_op = SOP_NONE;
        w_imm    = 24'h000000;
        case (w_opcode)
            OPC_INCRI: w_sca_op = SOP_INCI;
            OPC_INCRJ: w_sca_op = SOP_INCJ;
            OPC_SETN: begin
                w_sca_op = SOP_SETN;
                w_imm    = w_imm_field;
            end
            OPC_SUMFV,
            OPC_MULFV,
            OPC_NOP:   w_sca_op = SOP_NONE;
            default:   w_sca_op = SOP_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sca_op <= SOP_NONE;
            r_imm    <= 24'h000000;
        end else begin
            r_sca_op <= w_sca_op;
            r_imm    <= w_imm;
        end
    end

    assign sca_reg_op = r_sca_op;
    assign imm        = r_imm;

endmodule

// File: tb/tb_instr_decoder_id.sv
// Self-checking bench for instr_decoder_id: directed vector table, hand sequences
// for reset corner cases, and randomized stimulus against a lookup-table model.
module tb_instr_decoder_id;

    logic        clk;
    logic        rst;
    logic [29:0] instr;
    logic [1:0]  sca_reg_op;
    logic [23:0] imm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [29:0] instr;
        logic [1:0]  exp_op;
        logic [23:0] exp_imm;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] op_table[16];

    instr_decoder_id #(.ARQ(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .sca_reg_op (sca_reg_op),
        .imm        (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] exp_op, input logic [23:0] exp_imm);
        n_checks++;
        if (sca_reg_op !== exp_op || imm !== exp_imm) begin
            n_errors++;
            $display("FAIL %s: got op=%b imm=%h, expected op=%b imm=%h",
                     name, sca_reg_op, imm, exp_op, exp_imm);
        end
    endtask

    // Present inputs mid-cycle, let one rising edge capture them, sample shortly after.
    task automatic apply(input logic r, input logic [29:0] ins);
        @(negedge clk);
        rst   = r;
        instr = ins;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] mk(input logic [3:0] opc, input logic [1:0] rsv, input logic [23:0] f);
        return {opc, rsv, f};
    endfunction

    // Reference: the instruction's meaning from the opcode table; only SETN carries its field.
    task automatic model(input logic r, input logic [29:0] ins, output logic [1:0] op, output logic [23:0] im);
        int opc;
        opc = int'(ins[29:26]);
        if (r) begin
            op = 2'b00;
            im = 24'h0;
        end else begin
            op = op_table[opc];
            im = (opc == 2) ? ins[23:0] : 24'h0;
        end
    endtask

    initial begin
        logic [1:0]  e_op;
        logic [23:0] e_imm;
        logic [29:0] ri;
        logic        rr;

        for (int k = 0; k < 16; k++) op_table[k] = 2'b00;
        op_table[0] = 2'b01;
        op_table[1] = 2'b10;
        op_table[2] = 2'b11;

        vecs.push_back('{30'h00000000, 2'b01, 24'h000000, "incri"});
        vecs.push_back('{30'h04000000, 2'b10, 24'h000000, "incrj"});
        vecs.push_back('{30'h08000008, 2'b11, 24'h000008, "setn_8"});
        vecs.push_back('{30'h0BABCDEF, 2'b11, 24'hABCDEF, "setn_rsv11"});
        vecs.push_back('{30'h0C123456, 2'b00, 24'h000000, "sumfv"});
        vecs.push_back('{30'h10123456, 2'b00, 24'h000000, "mulfv"});
        vecs.push_back('{30'h14123456, 2'b00, 24'h000000, "nop"});
        vecs.push_back('{30'h03FFFFFF, 2'b01, 24'h000000, "incri_junk"});
        vecs.push_back('{30'h0B000000, 2'b11, 24'h000000, "setn_zero"});
        for (int k = 6; k < 16; k++)
            vecs.push_back('{mk(4'(k), 2'b11, 24'hFFFFFF), 2'b00, 24'h000000, $sformatf("undef_%0d", k)});

        // Unknown instruction during reset must still yield zeros.
        rst   = 1'b1;
        instr = 'x;
        @(posedge clk);
        #1;
        check("reset_x", 2'b00, 24'h0);

        apply(1'b1, mk(4'b0010, 2'b00, 24'hFFFFFF));
        check("reset_setn_1", 2'b00, 24'h0);
        apply(1'b1, mk(4'b0010, 2'b00, 24'hFFFFFF));
        check("reset_setn_2", 2'b00, 24'h0);
        apply(1'b0, mk(4'b0010, 2'b00, 24'hFFFFFF));
        check("release_setn", 2'b11, 24'hFFFFFF);

        // Outputs hold between edges even if the input changes.
        @(negedge clk);
        instr = 30'h04000000;
        #2;
        check("hold_between_edges", 2'b11, 24'hFFFFFF);

        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].instr);
            check(vecs[i].name, vecs[i].exp_op, vecs[i].exp_imm);
        end

        // Mid-stream reset discards the SETN, INCRJ resumes immediately after release.
        apply(1'b0, 30'h00000000);
        check("mid_incri", 2'b01, 24'h0);
        apply(1'b1, 30'h08000005);
        check("mid_rst_setn", 2'b00, 24'h0);
        apply(1'b0, 30'h04000000);
        check("mid_incrj", 2'b10, 24'h0);
        apply(1'b0, 30'h08000005);
        check("mid_setn5", 2'b11, 24'h000005);

        for (int n = 0; n < 400; n++) begin
            ri = 30'($urandom);
            if ($urandom_range(0, 1) == 0) ri[29:26] = 4'($urandom_range(0, 5));
            rr = ($urandom_range(0, 15) == 0);
            model(rr, ri, e_op, e_imm);
            apply(rr, ri);
            check($sformatf("rand_%0d", n), e_op, e_imm);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
